// File: rtl/sreg_sipo_9_bit_pkg.sv
// Shared constants and helpers for the 9-bit serial-in/parallel-out deserializer.
package sreg_sipo_9_bit_pkg;

  // Frame width of the LSB-first serial link fed by the matching PISO.
  localparam int unsigned SIPO_WIDTH = 9;

  // Bit-counter width for a given frame width; never narrower than one bit.
  function automatic int unsigned sipo_cnt_width(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sreg_sipo_9_bit.sv
// Serial-in/parallel-out deserializer with a single-entry valid/ready holding
// register and a sticky overrun flag for words dropped while the holder is full.
module sreg_sipo_9_bit
  import sreg_sipo_9_bit_pkg::*;
#(
  parameter  int unsigned WIDTH = SIPO_WIDTH,
  localparam int unsigned CNT_W = sipo_cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_serial,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_parallel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic             complete;
  logic             hold_free;
  logic             accept;

  // Frame word as it will look once the current bit is shifted in.
  always_comb begin
    word      = {in_serial, sreg[WIDTH-1:1]};
    last_bit  = in_valid && (bit_cnt == LAST_BIT);
    // A frame sync on the final bit realigns instead of producing a word.
    complete  = last_bit && !start;
    accept    = out_valid && out_ready;
    hold_free = !out_valid || out_ready;
    busy      = (bit_cnt != '0);
  end

  // Shift register: first received bit migrates down to bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (in_valid) begin
      sreg <= word;
    end
  end

  // Bit counter: wraps after a full frame, start realigns to bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (start) begin
      bit_cnt <= in_valid ? CNT_W'(1) : '0;
    end else if (in_valid) begin
      bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  // Holding register: load on completion if free, otherwise drain on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parallel <= '0;
      out_valid    <= 1'b0;
    end else if (complete && hold_free) begin
      out_parallel <= word;
      out_valid    <= 1'b1;
    end else if (accept) begin
      out_valid    <= 1'b0;
    end
  end

  // Sticky overrun: set when a completed word finds the holder occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (start) begin
      overrun <= 1'b0;
    end else if (complete && !hold_free) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sreg_sipo_9_bit.sv
// Scoreboard bench for sreg_sipo_9_bit: a frame-level reference model collects
// bits into a queue, queues each delivered word, and a monitor pops on handshake.
module tb_sreg_sipo_9_bit;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         in_serial;
  logic         in_valid;
  logic [W-1:0] out_parallel;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit           frame_bits[$];
  logic [W-1:0] sb_q[$];
  logic [W-1:0] m_word;
  bit           m_valid;
  bit           m_ovr;

  sreg_sipo_9_bit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_serial    (in_serial),
    .in_valid     (in_valid),
    .out_parallel (out_parallel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame assembled from a bit list, word value by arithmetic.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_bits.delete();
      sb_q.delete();
      m_word  = '0;
      m_valid = 0;
      m_ovr   = 0;
    end else begin
      bit delivered;
      bit consumed;
      delivered = 0;
      consumed  = m_valid && (out_ready === 1'b1);
      if (start) begin
        frame_bits.delete();
        m_ovr = 0;
        if (in_valid) frame_bits.push_back(in_serial);
      end else if (in_valid) begin
        frame_bits.push_back(in_serial);
        if (frame_bits.size() == W) begin
          int unsigned v;
          v = 0;
          for (int i = 0; i < W; i++) v += int'(frame_bits[i]) * (1 << i);
          frame_bits.delete();
          if (!m_valid || consumed) begin
            m_word    = W'(v);
            m_valid   = 1;
            delivered = 1;
            sb_q.push_back(W'(v));
          end else begin
            m_ovr = 1;
          end
        end
      end
      if (consumed && !delivered) m_valid = 0;
    end
  end

  // Monitor: per-cycle status against model, word popped on each handshake.
  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("busy", 32'(busy), 32'(frame_bits.size() != 0));
    check("out_parallel_hold", 32'(out_parallel), 32'(m_word));
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got word 0x%0h expected none at %0t", out_parallel, $time);
      end else begin
        check("sb_word", 32'(out_parallel), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int nbits, input bit sync, input int max_gap);
    for (int i = 0; i < nbits; i++) begin
      start     = (sync && i == 0);
      in_valid  = 1'b1;
      in_serial = w[i];
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      if (i != nbits - 1 && max_gap > 0) idle($urandom_range(max_gap, 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_serial = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("reset_out_parallel", 32'(out_parallel), 32'h000);
    check("reset_busy", 32'(busy), 32'h0);

    // Basic frame, out_ready low until one cycle after the word lands.
    send_bits(9'h1A5, 9, 1, 0);
    check("basic_valid", 32'(out_valid), 32'h1);
    check("basic_word", 32'(out_parallel), 32'h1A5);
    out_ready = 1'b1;
    idle(1);
    check("basic_consumed", 32'(out_valid), 32'h0);

    // Gapped input.
    send_bits(9'h1A5, 9, 1, 3);
    check("gapped_word", 32'(out_parallel), 32'h1A5);
    idle(2);

    // Back-to-back frames with no start.
    send_bits(9'h1A5, 9, 0, 0);
    check("b2b_first", 32'(out_parallel), 32'h1A5);
    send_bits(9'h05A, 9, 0, 0);
    check("b2b_second", 32'(out_parallel), 32'h05A);
    check("b2b_overrun", 32'(overrun), 32'h0);
    idle(2);

    // Overrun with consumer stalled, then start clears it.
    out_ready = 1'b0;
    send_bits(9'h1FF, 9, 0, 0);
    send_bits(9'h001, 9, 0, 1);
    check("ovr_word_kept", 32'(out_parallel), 32'h1FF);
    check("ovr_flag", 32'(overrun), 32'h1);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);
    out_ready = 1'b1;
    idle(2);

    // Resync: partial frame dropped, start carries bit 0.
    send_bits(9'h0F3, 4, 0, 0);
    check("resync_busy", 32'(busy), 32'h1);
    send_bits(9'h100, 9, 1, 0);
    check("resync_word", 32'(out_parallel), 32'h100);
    idle(2);

    // Reset mid-frame: async abort then a fresh word.
    out_ready = 1'b0;
    send_bits(9'h1FF, 9, 0, 0);
    send_bits(9'h0AA, 5, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'h0);
    check("rst_async_word", 32'(out_parallel), 32'h000);
    check("rst_async_busy", 32'(busy), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_bits(9'h0C3, 9, 0, 0);
    check("post_rst_word", 32'(out_parallel), 32'h0C3);
    out_ready = 1'b1;
    idle(2);

    // Randomized traffic: gaps, stalls, occasional frame syncs.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      in_serial = $urandom_range(1, 0);
      start     = ($urandom_range(39, 0) == 0);
      out_ready = $urandom_range(1, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    idle(3);
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sreg_sipo_9_bit.md
Name: sreg_sipo_9_bit

Overview:
Serial-in/parallel-out deserializer. It is the receive end of the 9-bit LSB-first serial link driven by the team's PISO shift register.
- Collects WIDTH qualified serial bits into a word.
- Presents the word on a valid/ready output with an overrun flag.
- Sits between the serial link and the parallel consumer logic in the VAE datapath.

Parameters:
WIDTH, 9, word width in bits and number of bits per frame
CNT_W, $clog2(WIDTH), bit-counter width (derived; do not override)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  frame sync: realigns the bit counter to bit 0 and clears overrun
in_serial  input  1  serial data bit, LSB first
in_valid  input  1  qualifies in_serial for this cycle
out_parallel  output  WIDTH  last completed word (holding register)
out_valid  output  1  out_parallel holds an unconsumed word
out_ready  input  1  consumer accepts the word when out_valid && out_ready
busy  output  1  partial frame in progress (bit_cnt != 0)
overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (rst_n=0, async) sets shift reg=0, bit_cnt=0, out_parallel=0, out_valid=0, overrun=0, busy=0. Release is synchronous to clk.
- Shift on in_valid: sreg <= {in_serial, sreg[WIDTH-1:1]}; bit_cnt += 1. The first received bit ends in bit 0, which mirrors the PISO's right shift.
- Cycles without in_valid: sreg and bit_cnt hold.
- start, without in_valid: bit_cnt <= 0 and overrun <= 0. The partial word is discarded. out_valid and out_parallel are unaffected.
- start with in_valid in the same cycle: the bit is captured as bit 0, so bit_cnt <= 1.
- Completion: when in_valid and bit_cnt==WIDTH-1, the assembled word {in_serial, sreg[WIDTH-1:1]} is the frame word. bit_cnt wraps to 0, so back-to-back frames need no start.
  - On that clock edge, if the holding register is free (!out_valid, or out_valid && out_ready this cycle): out_parallel <= word and out_valid <= 1.
  - Otherwise the word is dropped, out_parallel keeps its old value, and overrun <= 1 (sticky).
- Latency: out_valid rises on the same edge that samples the last bit (0 cycles after the final in_valid cycle).
- Handshake: out_valid && out_ready with no completion this cycle gives out_valid <= 0. out_parallel holds its value after it is consumed.
- Simultaneous accept and completion: out_valid stays 1, out_parallel takes the new word, no overrun.
- start on a completion cycle: start wins the counter (bit_cnt <= 1 if in_valid, else 0). No word is produced and overrun clears.
- busy = (bit_cnt != 0), combinational from the register.
- out_ready is ignored while out_valid=0.
- Asserting rst_n=0 mid-frame aborts immediately. All state returns to reset values.

Decomposition:
- No shared package needed; CNT_W is a localparam derived from WIDTH.
- Single module. An optional sub-module, sipo_bit_counter (wrapping mod-WIDTH counter with sync clear), is acceptable but not required.

Test Plan:
- Reset: rst_n=0 mid-stream, then release -> out_parallel=9'h000, out_valid=0, overrun=0, busy=0; the next 9 bits form a fresh word.
- Basic frame: start, then bits 1,0,1,0,0,1,0,1,1 on consecutive in_valid cycles -> out_parallel=9'h1A5, out_valid=1 on the 9th edge; out_ready=1 one cycle later -> out_valid=0.
- Gapped input: same 9 bits with in_valid low for 1-3 random cycles between bits -> out_parallel=9'h1A5; busy=1 from bit 1 through bit 8.
- Back-to-back with out_ready tied 1: 9'h1A5 then 9'h05A with no start -> two out_valid words in order, no gap cycle, overrun=0.
- Overrun: out_ready=0, send 9'h1FF then 9'h001 -> out_parallel stays 9'h1FF and overrun=1. A subsequent start clears overrun.
- Resync: send 4 bits, assert start with in_valid carrying bit 0 of 9'h100 -> the partial frame is dropped; after 8 more bits out_parallel=9'h100.
